// File: rtl/keypad_entry_pkg.sv
// rtl/keypad_entry_pkg.sv - shared constants, FSM states and key-code helpers for keypad_entry
package keypad_entry_pkg;

  localparam int          REG_W        = 32;
  localparam logic [15:0] SCAN_DIV_DEF = 16'd50000;
  localparam logic [3:0]  DEBOUNCE_DEF = 4'd4;
  localparam logic [3:0]  COL_INIT     = 4'b1110;
  localparam logic [3:0]  ROW_IDLE     = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_CAPTURE  = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_t;

  // Lowest-numbered active (low) row wins when several keys share a column.
  function automatic logic [1:0] low_row_idx(input logic [3:0] r);
    if (!r[0])      low_row_idx = 2'd0;
    else if (!r[1]) low_row_idx = 2'd1;
    else if (!r[2]) low_row_idx = 2'd2;
    else            low_row_idx = 2'd3;
  endfunction

  function automatic logic [1:0] col_idx(input logic [3:0] c);
    case (c)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] col_rot(input logic [3:0] c);
    col_rot = {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/keypad_entry_input_sync.sv
// rtl/keypad_entry_input_sync.sv - two-flop synchronizer for asynchronous board inputs
module input_sync #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - 4x4 hex keypad scanner with debounce, entry shifter and valid/ack hand-off
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = SCAN_DIV_DEF,
  parameter logic [3:0]  DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  input  logic             commit,
  input  logic             ack,
  output logic [REG_W-1:0] entry,
  output logic [3:0]       digit_cnt,
  output logic [REG_W-1:0] data,
  output logic             valid
);

  localparam logic [19:0] CM_LAST = 20'(DEBOUNCE) * 20'(SCAN_DIV) - 20'd1;

  logic [3:0]  row_s;
  logic        commit_s;
  scan_state_t state;
  logic [15:0] dwell_cnt;
  logic [3:0]  db_cnt;
  logic [3:0]  pat;
  logic [3:0]  code;
  logic [19:0] cm_cnt;
  logic        cm_level;
  logic        sample;
  logic        commit_ev;
  logic        capture;

  input_sync #(.WIDTH(4), .RST_VAL(ROW_IDLE)) u_row_sync (
    .clk(clk), .rst_n(rst_n), .d(row), .q(row_s)
  );

  input_sync #(.WIDTH(1), .RST_VAL(1'b0)) u_commit_sync (
    .clk(clk), .rst_n(rst_n), .d(commit), .q(commit_s)
  );

  assign sample    = (dwell_cnt == SCAN_DIV - 16'd1);
  assign capture   = (state == ST_CAPTURE);
  assign commit_ev = commit_s && !cm_level && (cm_cnt == CM_LAST);

  // The dwell counter free-runs; col only moves when the FSM lets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SCAN;
      col       <= COL_INIT;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      pat       <= ROW_IDLE;
      code      <= '0;
    end else begin
      dwell_cnt <= sample ? 16'd0 : dwell_cnt + 16'd1;
      case (state)
        ST_SCAN: if (sample) begin
          if (row_s != ROW_IDLE) begin
            pat    <= row_s;
            code   <= {low_row_idx(row_s), col_idx(col)};
            db_cnt <= 4'd1;
            state  <= (DEBOUNCE <= 4'd1) ? ST_CAPTURE : ST_DEBOUNCE;
          end else begin
            col <= col_rot(col);
          end
        end
        ST_DEBOUNCE: if (sample) begin
          if (row_s == pat) begin
            db_cnt <= db_cnt + 4'd1;
            if (db_cnt + 4'd1 >= DEBOUNCE) state <= ST_CAPTURE;
          end else begin
            state <= ST_SCAN;
            col   <= col_rot(col);
          end
        end
        ST_CAPTURE: begin
          state  <= ST_RELEASE;
          db_cnt <= '0;
        end
        ST_RELEASE: if (sample) begin
          if (row_s != ROW_IDLE) begin
            db_cnt <= '0;
          end else if (db_cnt + 4'd1 >= DEBOUNCE) begin
            state <= ST_SCAN;
            col   <= col_rot(col);
          end else begin
            db_cnt <= db_cnt + 4'd1;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

  // Commit button must stay high DEBOUNCE*SCAN_DIV cycles; its first qualified cycle is the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_cnt   <= '0;
      cm_level <= 1'b0;
    end else if (!commit_s) begin
      cm_cnt   <= '0;
      cm_level <= 1'b0;
    end else if (cm_cnt == CM_LAST) begin
      cm_level <= 1'b1;
    end else begin
      cm_cnt <= cm_cnt + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry     <= '0;
      digit_cnt <= '0;
      data      <= '0;
      valid     <= 1'b0;
    end else begin
      if (commit_ev && !valid) begin
        data      <= entry;
        valid     <= 1'b1;
        entry     <= capture ? {28'd0, code} : '0;
        digit_cnt <= capture ? 4'd1 : 4'd0;
      end else begin
        if (capture) begin
          entry     <= {entry[REG_W-5:0], code};
          digit_cnt <= (digit_cnt == 4'd8) ? 4'd8 : digit_cnt + 4'd1;
        end
        if (valid && ack) valid <= 1'b0;
      end
    end
  end

endmodule
